// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, result classes and the completion-stage wait FSM.
package cpu_pkg;

    // ALU-class opcodes
    localparam logic [5:0] OP_AND   = 6'h00;
    localparam logic [5:0] OP_OR    = 6'h01;
    localparam logic [5:0] OP_XOR   = 6'h02;
    localparam logic [5:0] OP_SHIFT = 6'h03;
    localparam logic [5:0] OP_ADD   = 6'h04;
    localparam logic [5:0] OP_SUB   = 6'h05;
    localparam logic [5:0] OP_CLT   = 6'h06;
    localparam logic [5:0] OP_CLTU  = 6'h07;
    localparam logic [5:0] OP_JMP   = 6'h08;
    localparam logic [5:0] OP_JMPR  = 6'h09;
    localparam logic [5:0] OP_IDX1  = 6'h0A;
    localparam logic [5:0] OP_IDX2  = 6'h0B;
    localparam logic [5:0] OP_IDX4  = 6'h0C;
    localparam logic [5:0] OP_LD    = 6'h0D;
    localparam logic [5:0] OP_LDPC  = 6'h0E;
    // Multiplier and divider
    localparam logic [5:0] OP_MUL   = 6'h0F;
    localparam logic [5:0] OP_DIVU  = 6'h10;
    localparam logic [5:0] OP_DIVS  = 6'h11;
    localparam logic [5:0] OP_MODU  = 6'h12;
    localparam logic [5:0] OP_MODS  = 6'h13;
    // Loads
    localparam logic [5:0] OP_LDB   = 6'h14;
    localparam logic [5:0] OP_LDH   = 6'h15;
    localparam logic [5:0] OP_LDW   = 6'h16;
    localparam logic [5:0] OP_LDBU  = 6'h17;
    localparam logic [5:0] OP_LDHU  = 6'h18;
    // Stores, branches and system operations (never write back)
    localparam logic [5:0] OP_STB   = 6'h19;
    localparam logic [5:0] OP_STH   = 6'h1A;
    localparam logic [5:0] OP_STW   = 6'h1B;
    localparam logic [5:0] OP_BEQ   = 6'h1C;
    localparam logic [5:0] OP_BNE   = 6'h1D;
    localparam logic [5:0] OP_BLT   = 6'h1E;
    localparam logic [5:0] OP_BGE   = 6'h1F;
    localparam logic [5:0] OP_BLTU  = 6'h20;
    localparam logic [5:0] OP_BGEU  = 6'h21;
    localparam logic [5:0] OP_CSR   = 6'h22;
    localparam logic [5:0] OP_RTE   = 6'h23;
    localparam logic [5:0] OP_SYS   = 6'h24;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_MUL,
        CLS_LOAD,
        CLS_DIV
    } result_class_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        WAIT_DIV,
        FULL
    } wait_state_e;

    // Which unit produces the writeback value for an opcode.
    function automatic result_class_e op_class(input logic [5:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_ADD, OP_SUB, OP_CLT, OP_CLTU,
            OP_JMP, OP_JMPR, OP_IDX1, OP_IDX2, OP_IDX4, OP_LD, OP_LDPC:
                op_class = CLS_ALU;
            OP_MUL:
                op_class = CLS_MUL;
            OP_DIVU, OP_DIVS, OP_MODU, OP_MODS:
                op_class = CLS_DIV;
            OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW:
                op_class = CLS_LOAD;
            default:
                op_class = CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_load_align.sv
// Load lane selection and sign/zero extension for byte, halfword and word loads.
module cpu_load_align
    import cpu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lsb,
    input  logic [31:0] raw,
    output logic [31:0] aligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Pick the addressed lane, then extend according to the load flavour.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        lane_byte = raw[7:0];
        lane_half = lsb[1] ? raw[31:16] : raw[15:0];
        aligned   = raw;
        case (lsb)
            2'd1:    lane_byte = raw[15:8];
            2'd2:    lane_byte = raw[23:16];
            2'd3:    lane_byte = raw[31:24];
            default: lane_byte = raw[7:0];
        endcase
        case (op)
            OP_LDB:  aligned = {{24{lane_byte[7]}}, lane_byte};
            OP_LDBU: aligned = {24'h000000, lane_byte};
            OP_LDH:  aligned = {{16{lane_half[15]}}, lane_half};
            OP_LDHU: aligned = {16'h0000, lane_half};
            default: aligned = raw;
        endcase
    end

endmodule

// File: rtl/cpu_complete.sv
// Memory/completion stage: waits for load or divider data, buffers responses
// that arrive while frozen, and drives the registered register-file write port.
module cpu_complete
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [5:0]  p3_op,
    input  logic [4:0]  p3_dest,
    input  logic [1:0]  p3_addr_lsb,
    input  logic        p3_misaligned_address,
    input  logic        p4_jump_taken,
    input  logic [31:0] p4_alu_out,
    input  logic [31:0] p4_mult,
    input  logic        cpud_rvalid,
    input  logic [31:0] cpud_rdata,
    input  logic        div_valid,
    input  logic [31:0] div_result,
    output logic        p4_busy,
    output logic        p5_reg_write,
    output logic [4:0]  p5_dest,
    output logic [31:0] p5_data
);

    logic [5:0]    p4_op;
    logic [4:0]    p4_dest;
    logic [1:0]    p4_lsb;
    logic          p4_valid;
    wait_state_e   state;
    wait_state_e   state_next;
    wait_state_e   entry_state;
    logic [31:0]   hold_data;
    logic          p3_valid;
    logic          resp_now;
    logic [31:0]   resp_data;
    logic [31:0]   raw_data;
    logic [31:0]   load_data;
    logic [31:0]   result;
    result_class_e p3_class;
    result_class_e p4_class;

    assign p3_class = op_class(p3_op);
    assign p4_class = op_class(p4_op);
    assign p3_valid = !p4_jump_taken && !p3_misaligned_address;

    // A response only counts in the wait state that expects it; anything else is spurious.
    assign resp_now  = ((state == WAIT_LOAD) && cpud_rvalid) || ((state == WAIT_DIV) && div_valid);
    assign resp_data = (state == WAIT_DIV) ? div_result : cpud_rdata;
    assign raw_data  = resp_now ? resp_data : hold_data;

    // Busy never looks at stall, so stall = f(p4_busy) cannot form a loop.
    assign p4_busy = ((state == WAIT_LOAD) && !cpud_rvalid) || ((state == WAIT_DIV) && !div_valid);

    // Wait state the incoming p3 instruction needs once it lands in p4.
    always_comb begin
        entry_state = IDLE;
        if (p3_valid && (p3_class == CLS_LOAD)) entry_state = WAIT_LOAD;
        else if (p3_valid && (p3_class == CLS_DIV)) entry_state = WAIT_DIV;
    end

    // Wait FSM next state: advance with the pipeline, park in FULL if data beats the stall.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:                if (!stall) state_next = entry_state;
            WAIT_LOAD, WAIT_DIV: if (resp_now) state_next = stall ? FULL : entry_state;
            FULL:                if (!stall) state_next = entry_state;
            default:             state_next = IDLE;
        endcase
    end

    // Wait FSM state register and response holding buffer.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= IDLE;
            hold_data <= 32'h0;
        end else begin
            state <= state_next;
            if (resp_now && stall) hold_data <= resp_data;
        end
    end

    // Capture the execute-stage control fields whenever the pipeline advances.
    always_ff @(posedge clock) begin
        if (reset) begin
            p4_valid <= 1'b0;
            p4_op    <= OP_SYS;
            p4_dest  <= 5'd0;
            p4_lsb   <= 2'd0;
        end else if (!stall) begin
            p4_valid <= p3_valid;
            p4_op    <= p3_op;
            p4_dest  <= p3_dest;
            p4_lsb   <= p3_addr_lsb;
        end
    end

    cpu_load_align u_load_align (
        .op      (p4_op),
        .lsb     (p4_lsb),
        .raw     (raw_data),
        .aligned (load_data)
    );

    // Final result mux by producing unit.
    always_comb begin
        result = 32'h0;
        case (p4_class)
            CLS_ALU:  result = p4_alu_out;
            CLS_MUL:  result = p4_mult;
            CLS_LOAD: result = load_data;
            CLS_DIV:  result = raw_data;
            default:  result = 32'h0;
        endcase
    end

    // Registered write port: exactly one strobe, on the edge the instruction leaves p4.
    always_ff @(posedge clock) begin
        if (reset) begin
            p5_reg_write <= 1'b0;
            p5_dest      <= 5'd0;
            p5_data      <= 32'h0;
        end else if (!stall) begin
            p5_reg_write <= p4_valid && (p4_class != CLS_NONE) && (p4_dest != 5'd0);
            p5_dest      <= p4_dest;
            p5_data      <= result;
        end else begin
            p5_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_complete.sv
// Scoreboard bench for cpu_complete: stimulus pushes expected writebacks,
// a negedge monitor pops and compares every p5 write.
module tb_cpu_complete;
    import cpu_pkg::*;

    logic        clock;
    logic        reset;
    logic        ext_stall;
    logic        stall;
    logic [5:0]  p3_op;
    logic [4:0]  p3_dest;
    logic [1:0]  p3_addr_lsb;
    logic        p3_misaligned_address;
    logic        p4_jump_taken;
    logic [31:0] p4_alu_out;
    logic [31:0] p4_mult;
    logic        cpud_rvalid;
    logic [31:0] cpud_rdata;
    logic        div_valid;
    logic [31:0] div_result;
    logic        p4_busy;
    logic        p5_reg_write;
    logic [4:0]  p5_dest;
    logic [31:0] p5_data;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_t;

    wb_t sb[$];
    int  n_vec    = 0;
    int  n_err    = 0;
    int  n_pushed = 0;
    int  n_writes = 0;

    // Global stall as the pipeline builds it: external freeze or this stage waiting.
    assign stall = ext_stall | p4_busy;

    cpu_complete dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .p3_op                 (p3_op),
        .p3_dest               (p3_dest),
        .p3_addr_lsb           (p3_addr_lsb),
        .p3_misaligned_address (p3_misaligned_address),
        .p4_jump_taken         (p4_jump_taken),
        .p4_alu_out            (p4_alu_out),
        .p4_mult               (p4_mult),
        .cpud_rvalid           (cpud_rvalid),
        .cpud_rdata            (cpud_rdata),
        .div_valid             (div_valid),
        .div_result            (div_result),
        .p4_busy               (p4_busy),
        .p5_reg_write          (p5_reg_write),
        .p5_dest               (p5_dest),
        .p5_data               (p5_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] dest, input logic [31:0] data);
        wb_t e;
        e.dest = dest;
        e.data = data;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_p3(input logic [5:0] op, input logic [4:0] dest, input logic [1:0] lsb,
                          input logic jump, input logic mis);
        p3_op                 = op;
        p3_dest               = dest;
        p3_addr_lsb           = lsb;
        p4_jump_taken         = jump;
        p3_misaligned_address = mis;
    endtask

    task automatic bubble();
        set_p3(OP_BEQ, 5'd0, 2'd0, 1'b1, 1'b0);
    endtask

    // Issue a load or divide, let it wait n_wait cycles, then deliver the response.
    task automatic run_resp(input logic [5:0] op, input logic [4:0] dest, input logic [1:0] lsb,
                            input logic is_div, input int n_wait, input logic [31:0] data,
                            input logic [31:0] exp, input string name);
        int busy_cnt;
        set_p3(op, dest, lsb, 1'b0, 1'b0);
        tick();
        bubble();
        busy_cnt = 0;
        for (int i = 0; i < n_wait; i++) begin
            #1;
            if (p4_busy) busy_cnt++;
            tick();
        end
        if (is_div) begin
            div_valid  = 1'b1;
            div_result = data;
        end else begin
            cpud_rvalid = 1'b1;
            cpud_rdata  = data;
        end
        expect_wb(dest, exp);
        #1;
        check({name, "_busy_on_data"}, {31'd0, p4_busy}, 32'd0);
        check({name, "_busy_cycles"}, busy_cnt, n_wait);
        tick();
        cpud_rvalid = 1'b0;
        div_valid   = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected writeback.
    always @(negedge clock) begin
        if (p5_reg_write === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: dest=%0d data=%h, expected no write", p5_dest, p5_data);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_dest", {27'd0, p5_dest}, {27'd0, e.dest});
                check("wb_data", p5_data, e.data);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        ext_stall   = 1'b0;
        p4_alu_out  = 32'h0;
        p4_mult     = 32'h0;
        cpud_rvalid = 1'b0;
        cpud_rdata  = 32'h0;
        div_valid   = 1'b0;
        div_result  = 32'h0;
        bubble();
        repeat (3) tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_busy", {31'd0, p4_busy}, 32'd0);
        check("rst_wr", {31'd0, p5_reg_write}, 32'd0);
        check("rst_dest", {27'd0, p5_dest}, 32'd0);
        check("rst_data", p5_data, 32'd0);
        check("rst_state", {30'd0, dut.state}, {30'd0, IDLE});

        // ALU op: writes one cycle after entering p4
        set_p3(OP_ADD, 5'd5, 2'd0, 1'b0, 1'b0);
        tick();
        bubble();
        p4_alu_out = 32'h12345678;
        expect_wb(5'd5, 32'h12345678);
        #1;
        check("alu_busy", {31'd0, p4_busy}, 32'd0);
        tick();
        check("alu_wr", {31'd0, p5_reg_write}, 32'd1);

        // MUL op
        set_p3(OP_MUL, 5'd3, 2'd0, 1'b0, 1'b0);
        tick();
        bubble();
        p4_mult = 32'h00000C00;
        expect_wb(5'd3, 32'h00000C00);
        tick();

        // Back-to-back zero-wait loads: LDB then LDBU on lane 2
        set_p3(OP_LDB, 5'd7, 2'd2, 1'b0, 1'b0);
        tick();
        set_p3(OP_LDBU, 5'd8, 2'd2, 1'b0, 1'b0);
        cpud_rvalid = 1'b1;
        cpud_rdata  = 32'h00AB0000;
        expect_wb(5'd7, 32'hFFFFFFAB);
        #1;
        check("ldb_busy", {31'd0, p4_busy}, 32'd0);
        tick();
        bubble();
        expect_wb(5'd8, 32'h000000AB);
        #1;
        check("ldbu_busy", {31'd0, p4_busy}, 32'd0);
        check("ldb_wr", {31'd0, p5_reg_write}, 32'd1);
        tick();
        cpud_rvalid = 1'b0;
        check("ldbu_wr", {31'd0, p5_reg_write}, 32'd1);

        // Halfword loads with a 3-cycle wait
        run_resp(OP_LDH,  5'd9,  2'd2, 1'b0, 3, 32'h80010000, 32'hFFFF8001, "ldh");
        run_resp(OP_LDHU, 5'd10, 2'd2, 1'b0, 3, 32'h80010000, 32'h00008001, "ldhu");
        // Word load with a 1-cycle wait, divider with a 2-cycle wait
        run_resp(OP_LDW,  5'd4,  2'd0, 1'b0, 1, 32'hA5A55A5A, 32'hA5A55A5A, "ldw");
        run_resp(OP_MODS, 5'd12, 2'd0, 1'b1, 2, 32'hFFFFFFFD, 32'hFFFFFFFD, "div");

        // Response while externally stalled: captured into FULL, one write after release
        set_p3(OP_LDW, 5'd11, 2'd0, 1'b0, 1'b0);
        tick();
        bubble();
        ext_stall   = 1'b1;
        cpud_rvalid = 1'b1;
        cpud_rdata  = 32'hCAFEBABE;
        expect_wb(5'd11, 32'hCAFEBABE);
        #1;
        check("full_busy", {31'd0, p4_busy}, 32'd0);
        tick();
        cpud_rvalid = 1'b0;
        check("full_state", {30'd0, dut.state}, {30'd0, FULL});
        for (int i = 0; i < 4; i++) begin
            cpud_rvalid = (i == 1);
            cpud_rdata  = (i == 1) ? 32'hDEADBEEF : 32'h0;
            #1;
            check("full_hold_wr", {31'd0, p5_reg_write}, 32'd0);
            tick();
        end
        cpud_rvalid = 1'b0;
        ext_stall   = 1'b0;
        tick();
        check("full_release_wr", {31'd0, p5_reg_write}, 32'd1);
        check("full_release_state", {30'd0, dut.state}, {30'd0, IDLE});
        tick();

        // Nullified load: no wait, spurious rvalid in IDLE ignored, no write
        set_p3(OP_LDW, 5'd13, 2'd0, 1'b1, 1'b0);
        tick();
        bubble();
        cpud_rvalid = 1'b1;
        cpud_rdata  = 32'h11111111;
        #1;
        check("null_busy", {31'd0, p4_busy}, 32'd0);
        check("null_state", {30'd0, dut.state}, {30'd0, IDLE});
        tick();
        cpud_rvalid = 1'b0;
        check("null_wr", {31'd0, p5_reg_write}, 32'd0);

        // Misaligned load: handled elsewhere, never waits or writes
        set_p3(OP_LDH, 5'd14, 2'd1, 1'b0, 1'b1);
        tick();
        bubble();
        #1;
        check("mis_busy", {31'd0, p4_busy}, 32'd0);
        tick();
        check("mis_wr", {31'd0, p5_reg_write}, 32'd0);

        // ALU op targeting r0
        set_p3(OP_ADD, 5'd0, 2'd0, 1'b0, 1'b0);
        tick();
        bubble();
        p4_alu_out = 32'h00000055;
        tick();
        check("r0_wr", {31'd0, p5_reg_write}, 32'd0);

        // Store: no write, no wait
        set_p3(OP_STW, 5'd14, 2'd0, 1'b0, 1'b0);
        tick();
        bubble();
        #1;
        check("store_busy", {31'd0, p4_busy}, 32'd0);
        tick();
        check("store_wr", {31'd0, p5_reg_write}, 32'd0);

        // Reset in WAIT_DIV, then a late divider pulse
        set_p3(OP_DIVS, 5'd15, 2'd0, 1'b0, 1'b0);
        tick();
        bubble();
        #1;
        check("rstwait_busy_before", {31'd0, p4_busy}, 32'd1);
        check("rstwait_state_before", {30'd0, dut.state}, {30'd0, WAIT_DIV});
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        div_valid  = 1'b1;
        div_result = 32'h00000099;
        #1;
        check("rstwait_busy_after", {31'd0, p4_busy}, 32'd0);
        tick();
        div_valid = 1'b0;
        check("rstwait_wr", {31'd0, p5_reg_write}, 32'd0);
        check("rstwait_state", {30'd0, dut.state}, {30'd0, IDLE});

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);
        check("write_count", n_writes, n_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
